// File: rtl/ws_pkg.sv
// Shared defaults, FSM state type and lane helper for the weight-stationary feeder.
package ws_pkg;
  localparam int WS_BIT_WIDTH = 8;
  localparam int WS_SIZE      = 4;

  typedef enum logic [1:0] {IDLE, LOAD_WT, STREAM, DRAIN} feeder_state_t;

  function automatic logic [WS_BIT_WIDTH-1:0] lane_slice(
    input logic [WS_BIT_WIDTH*WS_SIZE-1:0] v,
    input int unsigned                     idx
  );
    return v[idx*WS_BIT_WIDTH +: WS_BIT_WIDTH];
  endfunction
endpackage

// File: rtl/ws_skew_line.sv
// Fixed-latency data+valid delay line; output appears DELAY cycles after input.
module ws_skew_line #(
  parameter int DELAY     = 1,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [BIT_WIDTH-1:0] d_in,
  input  logic                 v_in,
  output logic [BIT_WIDTH-1:0] d_out,
  output logic                 v_out
);
  logic [DELAY:1][BIT_WIDTH-1:0] dat_pipe;
  logic [DELAY:1]                vld_pipe;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      dat_pipe[1] <= d_in;
      vld_pipe[1] <= v_in;
      for (int k = 2; k <= DELAY; k++) begin
        dat_pipe[k] <= dat_pipe[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
    end
  end

  assign d_out = dat_pipe[DELAY];
  assign v_out = vld_pipe[DELAY];
endmodule

// File: rtl/ws_feeder4x4.sv
// Job sequencer for the 4x4 weight-stationary array: weight load, skewed activations, drain.
module ws_feeder4x4
  import ws_pkg::*;
#(
  parameter int BIT_WIDTH = WS_BIT_WIDTH,
  parameter int SIZE      = WS_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIT_WIDTH*SIZE-1:0] wt_in,
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [BIT_WIDTH*SIZE-1:0] act_in,
  input  logic                      act_valid,
  input  logic                      act_last,
  output logic                      act_ready,
  output logic                      control,
  output logic [BIT_WIDTH*SIZE-1:0] wt_arr,
  output logic [BIT_WIDTH*SIZE-1:0] data_arr,
  output logic [SIZE-1:0]           lane_valid,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(SIZE) + 1;

  feeder_state_t state;
  logic [CW-1:0] wt_cnt, drain_cnt;

  logic [SIZE-1:0][BIT_WIDTH-1:0] inj_d, out_d;
  logic                           inj_v, skew_clr;

  assign wt_ready  = (state == LOAD_WT);
  assign act_ready = (state == STREAM);
  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN) && (drain_cnt == CW'(SIZE-1));
  assign skew_clr  = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wt_cnt    <= '0;
      drain_cnt <= '0;
      control   <= 1'b0;
      wt_arr    <= '0;
    end else begin
      control <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= LOAD_WT;
          wt_cnt <= '0;
        end
        LOAD_WT: if (wt_valid) begin
          control <= 1'b1;
          wt_arr  <= wt_in;
          wt_cnt  <= wt_cnt + 1'b1;
          if (wt_cnt == CW'(SIZE-1)) state <= STREAM;
        end
        STREAM: if (act_valid && act_last) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-handshake cycles in STREAM inject zero bubbles so lane timing stays fixed.
  always_comb begin
    inj_v = (state == STREAM) && act_valid;
    inj_d = '0;
    if (inj_v) inj_d = act_in;
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    ws_skew_line #(.DELAY(i+1), .BIT_WIDTH(BIT_WIDTH)) u_skew (
      .clk   (clk),
      .rst   (rst),
      .clr   (skew_clr),
      .d_in  (inj_d[i]),
      .v_in  (inj_v),
      .d_out (out_d[i]),
      .v_out (lane_valid[i])
    );
  end

  assign data_arr = out_d;
endmodule

// File: tb/tb_ws_feeder4x4.sv
// Directed self-checking bench for ws_feeder4x4.
module tb_ws_feeder4x4;
  import ws_pkg::*;

  logic        clk = 0, rst = 1, start = 0;
  logic [31:0] wt_in = '0, act_in = '0;
  logic        wt_valid = 0, act_valid = 0, act_last = 0;
  logic        wt_ready, act_ready, control, busy, done;
  logic [31:0] wt_arr, data_arr;
  logic [3:0]  lane_valid;

  int total = 0, bad = 0;
  logic [31:0] rows [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

  ws_feeder4x4 dut (
    .clk(clk), .rst(rst), .start(start), .wt_in(wt_in), .wt_valid(wt_valid),
    .wt_ready(wt_ready), .act_in(act_in), .act_valid(act_valid), .act_last(act_last),
    .act_ready(act_ready), .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
    .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Ends in the first STREAM cycle.
  task automatic load_weights;
    start = 1; tick; start = 0;
    for (int j = 0; j < 4; j++) begin
      wt_valid = 1; wt_in = rows[j]; tick;
    end
    wt_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin tick; n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s idle timeout: busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1; tick; tick;
    total++;
    if ({control, wt_arr, data_arr, lane_valid, done, busy, wt_ready, act_ready} !== '0) begin
      bad++; $display("FAIL reset outputs: got ctl=%b wt=%h d=%h lv=%b dn=%b bz=%b wr=%b ar=%b want all 0",
                      control, wt_arr, data_arr, lane_valid, done, busy, wt_ready, act_ready);
    end
    rst = 0;
    wt_valid = 1; act_valid = 1; tick;
    total++;
    if ({busy, control, wt_ready, act_ready} !== 4'b0) begin
      bad++; $display("FAIL idle ignores valid: got bz/ctl/wr/ar=%b want 0000", {busy, control, wt_ready, act_ready});
    end
    wt_valid = 0; act_valid = 0;
  endtask

  task automatic test_back_to_back;
    start = 1; tick; start = 0;
    total++;
    if ({busy, wt_ready, act_ready} !== 3'b110) begin
      bad++; $display("FAIL load_wt flags: got bz/wr/ar=%b want 110", {busy, wt_ready, act_ready});
    end
    for (int j = 0; j < 4; j++) begin
      wt_valid = 1; wt_in = rows[j]; tick;
      total++;
      if (control !== 1'b1 || wt_arr !== rows[j]) begin
        bad++; $display("FAIL b2b row %0d: got ctl=%b wt=%h want ctl=1 wt=%h", j, control, wt_arr, rows[j]);
      end
    end
    wt_valid = 0;
    total++;
    if ({wt_ready, act_ready} !== 2'b01) begin
      bad++; $display("FAIL stream flags: got wr/ar=%b want 01", {wt_ready, act_ready});
    end
    tick;
    total++;
    if (control !== 1'b0 || wt_arr !== rows[3]) begin
      bad++; $display("FAIL b2b after: got ctl=%b wt=%h want ctl=0 wt=%h", control, wt_arr, rows[3]);
    end
    act_valid = 1; act_last = 1; act_in = 32'h0; tick;
    act_valid = 0; act_last = 0;
    wait_idle("b2b");
  endtask

  task automatic test_gapped_wt;
    logic [31:0] g [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    logic [31:0] exp_wt;
    logic        v;
    int          beats;
    exp_wt = rows[3]; beats = 0;
    start = 1; tick; start = 0;
    for (int j = 0; j < 8; j++) begin
      v = (j % 2 == 0);
      wt_valid = v; wt_in = v ? g[j/2] : 32'hDEADBEEF; tick;
      if (v) exp_wt = g[j/2];
      if (control) beats++;
      total++;
      if (control !== v || wt_arr !== exp_wt) begin
        bad++; $display("FAIL gapped cyc %0d: got ctl=%b wt=%h want ctl=%b wt=%h", j, control, wt_arr, v, exp_wt);
      end
    end
    wt_valid = 1; wt_in = 32'h5555AAAA; tick;
    if (control) beats++;
    wt_valid = 0;
    total++;
    if (beats != 4 || wt_arr !== g[3]) begin
      bad++; $display("FAIL gapped beats: got %0d wt=%h want 4 wt=%h", beats, wt_arr, g[3]);
    end
    act_valid = 1; act_last = 1; tick;
    act_valid = 0; act_last = 0;
    wait_idle("gapped");
  endtask

  task automatic test_single_vector;
    logic [31:0] exp_d [5] = '{32'h00000004, 32'h00000300, 32'h00020000, 32'h01000000, 32'h0};
    logic [3:0]  exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    load_weights;
    act_in = 32'h01020304; act_valid = 1; act_last = 1; tick;
    act_valid = 0; act_last = 0; act_in = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (data_arr !== exp_d[c] || lane_valid !== exp_v[c] || done !== (c == 3) || busy !== (c < 4)) begin
        bad++; $display("FAIL single t+%0d: got d=%h lv=%b dn=%b bz=%b want d=%h lv=%b dn=%b bz=%b",
                        c+1, data_arr, lane_valid, done, busy, exp_d[c], exp_v[c], c == 3, c < 4);
      end
      tick;
    end
  endtask

  task automatic test_bubble;
    logic [31:0] sd [5] = '{32'h14131211, 32'h24232221, 32'h0, 32'h34333231, 32'h44434241};
    logic        sv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ed;
    logic [3:0]  ev;
    int          s;
    load_weights;
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        act_valid = sv[c]; act_in = sv[c] ? sd[c] : 32'hCAFEF00D; act_last = (c == 4);
      end else begin
        act_valid = 0; act_last = 0;
      end
      tick;
      ed = '0; ev = '0;
      for (int i = 0; i < 4; i++) begin
        s = c - i;
        if (s >= 0 && s < 5 && sv[s]) begin
          ed[i*8 +: 8] = lane_slice(sd[s], i);
          ev[i] = 1'b1;
        end
      end
      total++;
      if (data_arr !== ed || lane_valid !== ev || done !== (c == 7)) begin
        bad++; $display("FAIL bubble cyc %0d: got d=%h lv=%b dn=%b want d=%h lv=%b dn=%b",
                        c+1, data_arr, lane_valid, done, ed, ev, c == 7);
      end
    end
    wait_idle("bubble");
  endtask

  task automatic test_start_ignored;
    int beats, dones;
    beats = 0; dones = 0;
    start = 1; tick; start = 0;
    for (int j = 0; j < 4; j++) begin
      wt_valid = 1; wt_in = rows[j]; start = (j == 1); tick;
      beats += control; dones += done;
    end
    wt_valid = 0; start = 0;
    act_valid = 1; act_last = 1; act_in = 32'h11223344; tick;
    beats += control; dones += done;
    act_valid = 0; act_last = 0;
    start = 1; tick; start = 0;
    beats += control; dones += done;
    for (int k = 0; k < 10; k++) begin
      tick; beats += control; dones += done;
    end
    total++;
    if (beats != 4 || dones != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL start ignored: got beats=%0d dones=%0d bz=%b want 4 1 0", beats, dones, busy);
    end
  endtask

  task automatic test_reset_mid_stream;
    load_weights;
    act_valid = 1; act_in = 32'hAABBCCDD; tick;
    act_in = 32'h99887766; tick;
    act_valid = 0; rst = 1; tick; rst = 0;
    total++;
    if ({control, wt_arr, data_arr, lane_valid, done, busy, wt_ready, act_ready} !== '0) begin
      bad++; $display("FAIL mid reset: got ctl=%b wt=%h d=%h lv=%b dn=%b bz=%b wr=%b ar=%b want all 0",
                      control, wt_arr, data_arr, lane_valid, done, busy, wt_ready, act_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      total++;
      if (data_arr !== 32'h0 || lane_valid !== 4'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL post reset %0d: got d=%h lv=%b bz=%b want 0 0 0", k, data_arr, lane_valid, busy);
      end
    end
    test_single_vector;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_gapped_wt;
    test_single_vector;
    test_bubble;
    test_start_ignored;
    test_reset_mid_stream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ws_feeder4x4.md
Name: ws_feeder4x4

Overview:
- Upstream stage of ws_top4x4, the 4x4 weight-stationary systolic array. Sequences one job per start pulse:
  - accepts SIZE weight rows over a valid/ready handshake and drives them onto wt_arr with control=1;
  - accepts activation vectors and drives them onto data_arr with the diagonal skew the array needs;
  - flushes the skew with zeros, then pulses done.
- Owns all timing of control, wt_arr and data_arr, so the array never sees a hand-built stimulus schedule.

Parameters:
- BIT_WIDTH, 8, width of one weight/activation element.
- SIZE, 4, array dimension; lanes per vector and weight rows per job.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle job start; honoured only in IDLE.
- wt_in  in  BIT_WIDTH*SIZE  one weight row; lane i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- wt_valid  in  1  wt_in valid.
- wt_ready  out  1  high only in LOAD_WT.
- act_in  in  BIT_WIDTH*SIZE  one activation vector, same lane packing.
- act_valid  in  1  act_in valid.
- act_last  in  1  marks final vector of job; sampled with act_valid&act_ready.
- act_ready  out  1  high only in STREAM.
- control  out  1  to array: 1 = weight-load beat, 0 = compute.
- wt_arr  out  BIT_WIDTH*SIZE  to array weight input.
- data_arr  out  BIT_WIDTH*SIZE  to array data input, skewed.
- lane_valid  out  SIZE  bit i = data_arr lane i carries a real element this cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when job completes.

Behaviour:
- Reset (also mid-job): state=IDLE. control, wt_arr, data_arr, lane_valid, done, busy, wt_ready and act_ready all 0. Skew registers cleared; counters 0.
- FSM states: IDLE, LOAD_WT, STREAM, DRAIN.
- IDLE:
  - start -> LOAD_WT, wt_cnt=0, skew registers cleared.
  - wt_valid and act_valid are ignored.
- LOAD_WT:
  - wt_ready=1. On a handshake: wt_arr<=wt_in and control<=1 next cycle, wt_cnt++.
  - Cycle with no handshake: control<=0 and wt_arr holds its value.
  - Handshake with wt_cnt==SIZE-1 -> STREAM.
  - Result: exactly SIZE control=1 cycles per job, each carrying a fresh row in accept order.
- STREAM:
  - act_ready=1. The skew path is entered every cycle.
  - On a handshake: lane i element enters the lane-i delay line with valid=1.
  - Cycle with no handshake: zeros with valid=0 are injected as a bubble.
  - Handshake with act_last=1 -> DRAIN, drain_cnt=0.
- Skew (registered):
  - Element of lane i accepted at cycle t appears on data_arr lane i at t+1+i, with lane_valid[i]=1.
  - Lane 0 therefore has 1-cycle latency; lane SIZE-1 has SIZE-cycle latency.
- DRAIN:
  - Zeros with valid=0 are injected each cycle; drain_cnt++.
  - When drain_cnt==SIZE-1: assert done for one cycle -> IDLE. At that point lane SIZE-1 of the last vector has been emitted.
- control is 0 in STREAM and DRAIN. wt_arr holds its last row until the next LOAD_WT.
- start while busy is ignored; no queueing.
- A job with act_last on the first vector is legal: STREAM lasts 1 handshake cycle.
- Arithmetic: counters are $clog2(SIZE)+1 bits and never wrap in a legal job. No data arithmetic; elements pass through unmodified.

Decomposition:
- Package ws_pkg holds:
  - BIT_WIDTH and SIZE defaults;
  - feeder_state_t enum {IDLE, LOAD_WT, STREAM, DRAIN};
  - a lane-slice helper function.
- One sub-module: ws_skew_line.
  - Parameters DELAY, BIT_WIDTH; data + valid shift register with synchronous clear.
  - Instantiated once per lane i with DELAY=i+1.

Test Plan:
- Reset mid-STREAM (rst high for 1 cycle after 2 vectors) -> next cycle all outputs 0, busy=0, state IDLE; a following start runs a clean job.
- start, then 4 back-to-back weight rows 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10 -> control=1 for exactly 4 consecutive cycles with wt_arr equal to those rows in order, then control=0.
- Weight rows with wt_valid gapped (1 on, 1 off) -> control pulses only on accepted beats, 4 in total; wt_arr held during gaps.
- Single vector {8'h01,8'h02,8'h03,8'h04} with act_last, accepted at cycle t -> lane0=8'h04 at t+1, lane1=8'h03 at t+2, lane2=8'h02 at t+3, lane3=8'h01 at t+4; lane_valid one-hot on the matching bit each cycle; done at t+4.
- 4 vectors with act_valid low for one cycle between vectors 2 and 3 -> that bubble appears as data 0 with lane_valid[i]=0 on each lane i at its skewed cycle; other lanes are unaffected.
- start pulsed during LOAD_WT and during DRAIN -> ignored: exactly 4 control beats per job, and exactly one done per job.
